// File: rtl/seq_pkg.sv
// Shared encodings for the datapath sequencer: opcodes, FSM states,
// ControlWord bit positions and instruction field positions.
package seq_pkg;

    localparam int INSTR_W = 18;
    localparam int CW_W    = 13;

    // Opcodes; 8..15 are unassigned and execute as NOP.
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ALU  = 4'd1;
    localparam logic [3:0] OP_ALUI = 4'd2;
    localparam logic [3:0] OP_LD   = 4'd3;
    localparam logic [3:0] OP_ST   = 4'd4;
    localparam logic [3:0] OP_BRZ  = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    // ControlWord = {DA, AA, BA, MB, FS, MD, RW}
    localparam int CW_DA_HI = 12;
    localparam int CW_DA_LO = 11;
    localparam int CW_AA_HI = 10;
    localparam int CW_AA_LO = 9;
    localparam int CW_BA_HI = 8;
    localparam int CW_BA_LO = 7;
    localparam int CW_MB    = 6;
    localparam int CW_FS_HI = 5;
    localparam int CW_FS_LO = 2;
    localparam int CW_MD    = 1;
    localparam int CW_RW    = 0;

    // Instruction = {OPC, DR, SA, SB, FS, IMM}
    localparam int OPC_HI = 17;
    localparam int OPC_LO = 14;
    localparam int DR_HI  = 13;
    localparam int DR_LO  = 12;
    localparam int SA_HI  = 11;
    localparam int SA_LO  = 10;
    localparam int SB_HI  = 9;
    localparam int SB_LO  = 8;
    localparam int FS_HI  = 7;
    localparam int FS_LO  = 4;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

    function automatic logic [3:0] ir_opcode(input logic [INSTR_W-1:0] ir);
        return ir[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decoder: IR + state -> ControlWord/ConstantOut.
// Only EXEC and MEM drive a non-zero control word, so the datapath never
// writes a register while the sequencer is idle, fetching or halted.
module seq_decode
    import seq_pkg::*;
(
    input  state_t               state,
    input  logic [INSTR_W-1:0]   ir,
    input  logic                 dmem_ack,
    output logic [CW_W-1:0]      control_word,
    output logic [3:0]           constant_out
);

    logic [3:0] opc;
    logic       active;

    assign opc    = ir_opcode(ir);
    assign active = (state == S_EXEC) || (state == S_MEM);

    // Field decode per opcode; a load only writes back in the cycle the data arrives.
    always_comb begin
        control_word = '0;
        constant_out = '0;
        if (active) begin
            case (opc)
                OP_ALU, OP_ALUI: begin
                    control_word[CW_DA_HI:CW_DA_LO] = ir[DR_HI:DR_LO];
                    control_word[CW_AA_HI:CW_AA_LO] = ir[SA_HI:SA_LO];
                    control_word[CW_BA_HI:CW_BA_LO] = ir[SB_HI:SB_LO];
                    control_word[CW_FS_HI:CW_FS_LO] = ir[FS_HI:FS_LO];
                    control_word[CW_RW]             = 1'b1;
                    if (opc == OP_ALUI) begin
                        control_word[CW_MB] = 1'b1;
                        constant_out        = ir[IMM_HI:IMM_LO];
                    end
                end
                OP_LD: begin
                    control_word[CW_DA_HI:CW_DA_LO] = ir[DR_HI:DR_LO];
                    control_word[CW_AA_HI:CW_AA_LO] = ir[SA_HI:SA_LO];
                    control_word[CW_MD]             = 1'b1;
                    control_word[CW_RW]             = (state == S_MEM) && dmem_ack;
                end
                OP_ST: begin
                    control_word[CW_AA_HI:CW_AA_LO] = ir[SA_HI:SA_LO];
                    control_word[CW_BA_HI:CW_BA_LO] = ir[SB_HI:SB_LO];
                end
                OP_BRZ: begin
                    control_word[CW_AA_HI:CW_AA_LO] = ir[SA_HI:SA_LO];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control unit for the 4-register, 4-bit datapath.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | after reset, waiting for start
// FETCH | imem_req high, waiting for imem_ack to latch IR
// EXEC  | one cycle of decoded control; resolves PC / next state
// MEM   | LD/ST in flight, dmem_req high until dmem_ack
// HALT  | stopped by HALT, PC held, waiting for start
module datapath_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int IW   = INSTR_W
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [IW-1:0]   imem_data,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    input  logic [3:0]      a_bus,
    output logic [CW_W-1:0] ControlWord,
    output logic [3:0]      ConstantOut,
    output logic            busy,
    output logic            halted
);

    localparam logic [PC_W-1:0] PC_ONE = 1;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [IW-1:0]   ir, ir_nxt;
    logic [3:0]      opc;
    logic [PC_W-1:0] br_off;

    assign opc    = ir[OPC_HI:OPC_LO];
    // Signed 4-bit offset widened to the PC; the add then wraps naturally.
    assign br_off = {{(PC_W-4){ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]};

    // State, PC and IR registers; reset drops any outstanding request at once.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    // Next-state, PC update and handshake outputs.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_nxt    = '0;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_nxt    = imem_data;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opc)
                    OP_LD, OP_ST: begin
                        state_nxt = S_MEM;
                    end
                    OP_BRZ: begin
                        pc_nxt    = (a_bus == 4'd0) ? pc + br_off : pc + PC_ONE;
                        state_nxt = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_nxt    = pc + br_off;
                        state_nxt = S_FETCH;
                    end
                    OP_HALT: begin
                        state_nxt = S_HALT;
                    end
                    default: begin
                        pc_nxt    = pc + PC_ONE;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opc == OP_ST);
                if (dmem_ack) begin
                    pc_nxt    = pc + PC_ONE;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign imem_addr = pc;
    assign busy      = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM);
    assign halted    = (state == S_HALT);

    seq_decode u_decode (
        .state        (state),
        .ir           (ir[INSTR_W-1:0]),
        .dmem_ack     (dmem_ack),
        .control_word (ControlWord),
        .constant_out (ConstantOut)
    );

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with a per-cycle reference model.
module tb_datapath_sequencer;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b1;
    logic        start = 1'b0;
    logic        imem_ack = 1'b0;
    logic [17:0] imem_data = '0;
    logic        dmem_ack = 1'b0;
    logic [3:0]  a_bus = '0;
    logic        imem_req, dmem_req, dmem_we, busy, halted;
    logic [7:0]  imem_addr;
    logic [12:0] ControlWord;
    logic [3:0]  ConstantOut;

    int passes = 0;
    int total  = 0;

    datapath_sequencer #(.PC_W(8), .IW(18)) dut (
        .CLK(CLK), .RSTn(RSTn), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .a_bus(a_bus), .ControlWord(ControlWord), .ConstantOut(ConstantOut),
        .busy(busy), .halted(halted)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [17:0] enc(input int opc, input int dr, input int sa,
                                        input int sb, input int fs, input int imm);
        return {opc[3:0], dr[1:0], sa[1:0], sb[1:0], fs[3:0], imm[3:0]};
    endfunction

    // Reference model: the programmer-visible machine as the rules describe it.
    typedef enum int {P_IDLE, P_FETCH, P_EXEC, P_MEM, P_HALT} phase_t;
    phase_t      ph  = P_IDLE;
    int          mpc = 0;
    logic [17:0] mir = '0;

    function automatic int wrap_add(input int pc, input logic [3:0] imm);
        int off;
        off = imm[3] ? int'(imm) - 16 : int'(imm);
        return ((pc + off) % 256 + 256) % 256;
    endfunction

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ph = P_IDLE; mpc = 0; mir = '0;
        end else begin
            case (ph)
                P_IDLE, P_HALT: if (start) begin mpc = 0; ph = P_FETCH; end
                P_FETCH: if (imem_ack) begin mir = imem_data; ph = P_EXEC; end
                P_EXEC: begin
                    case (int'(mir[17:14]))
                        3, 4: ph = P_MEM;
                        5: begin mpc = (a_bus == 0) ? wrap_add(mpc, mir[3:0]) : (mpc + 1) % 256; ph = P_FETCH; end
                        6: begin mpc = wrap_add(mpc, mir[3:0]); ph = P_FETCH; end
                        7: ph = P_HALT;
                        default: begin mpc = (mpc + 1) % 256; ph = P_FETCH; end
                    endcase
                end
                P_MEM: if (dmem_ack) begin mpc = (mpc + 1) % 256; ph = P_FETCH; end
                default: ph = P_IDLE;
            endcase
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge CLK) begin
        logic [12:0] e, m;
        logic [3:0]  ec, mc;
        int          opc;
        logic [1:0]  dr, sa, sb;
        logic [3:0]  fs, imm;
        e = '0; m = '1; ec = '0; mc = '1;
        opc = int'(mir[17:14]);
        dr = mir[13:12]; sa = mir[11:10]; sb = mir[9:8]; fs = mir[7:4]; imm = mir[3:0];
        if (ph == P_EXEC || ph == P_MEM) begin
            mc = '0;
            case (opc)
                1, 2: begin
                    e = {dr, sa, sb, (opc == 2), fs, 1'b0, 1'b1};
                    if (opc == 2) begin ec = imm; mc = '1; end
                end
                3: begin
                    e = {dr, sa, 2'b00, 1'b0, 4'b0000, 1'b1, (ph == P_MEM) && dmem_ack};
                    m = 13'b11_11_00_0_0000_1_1;
                end
                4: begin
                    e = {2'b00, sa, sb, 1'b0, 4'b0000, 1'b0, 1'b0};
                    m = 13'b00_11_11_1_0000_0_1;
                end
                5: begin
                    e = {2'b00, sa, 9'b0};
                    m = 13'b00_11_00_0_0000_0_1;
                end
                default: m = 13'b00_00_00_0_0000_0_1;
            endcase
        end
        chk("m_cw", ControlWord & m, e & m);
        if (mc != 0) chk("m_const", ConstantOut & mc, ec & mc);
        chk("m_imem_req", imem_req, ph == P_FETCH);
        chk("m_imem_addr", imem_addr, mpc);
        chk("m_dmem_req", dmem_req, ph == P_MEM);
        if (ph == P_MEM) chk("m_dmem_we", dmem_we, opc == 4);
        chk("m_busy", busy, ph == P_FETCH || ph == P_EXEC || ph == P_MEM);
        chk("m_halted", halted, ph == P_HALT);
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    // Wait (bounded) for a fetch, stall wait_cyc cycles, then ack; returns in EXEC.
    task automatic do_fetch(input logic [17:0] instr, input int wait_cyc);
        int n = 0;
        while (!imem_req && n < 20) begin step(); n++; end
        chk("fetch_wait", imem_req, 1'b1);
        repeat (wait_cyc) step();
        imem_data = instr;
        imem_ack  = 1'b1;
        step();
        imem_ack  = 1'b0;
    endtask

    task automatic jmp_to(input int imm, input int target, input string nm);
        do_fetch(enc(6, 0, 0, 0, 0, imm), 0);
        step(); #1 chk(nm, imem_addr, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        #1 RSTn = 1'b0;
        step(); step();
        #1 chk("rst_cw", ControlWord, 0);
        chk("rst_busy", busy, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        RSTn = 1'b1;
        step(); start = 1'b1; step(); start = 1'b0;
        #1 chk("start_fetch", imem_req, 1);

        // PC0: ALUI R1, FS=0010, IMM=5 with a one-cycle fetch stall
        do_fetch(enc(2, 1, 0, 0, 4'b0010, 5), 1);
        #1 chk("alui_cw", ControlWord & 13'b11_00_00_1_1111_1_1, 13'b01_00_00_1_0010_0_1);
        chk("alui_const", ConstantOut, 5);
        step(); #1 chk("alui_one_exec", imem_req, 1);
        chk("alui_next_addr", imem_addr, 1);

        // PC1: LD R2,[R1], ack on the fourth MEM cycle
        do_fetch(enc(3, 2, 1, 0, 0, 0), 0);
        #1 chk("ld_exec_rw", ControlWord[0], 0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) dmem_ack = 1'b1;
            #1 chk("ld_req", dmem_req, 1);
            chk("ld_we", dmem_we, 0);
            chk("ld_md", ControlWord[1], 1);
            chk("ld_rw", ControlWord[0], i == 3);
        end
        step(); dmem_ack = 1'b0;
        #1 chk("ld_done_addr", imem_addr, 2);
        chk("ld_done_req", dmem_req, 0);

        // PC2: ST [R1],R3; a stray start while fetching must be ignored
        start = 1'b1; step(); start = 1'b0;
        do_fetch(enc(4, 0, 1, 3, 0, 0), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) dmem_ack = 1'b1;
            #1 chk("st_we", dmem_we, 1);
            chk("st_rw", ControlWord[0], 0);
            chk("st_ba", ControlWord[8:7], 2'b11);
            chk("st_mb", ControlWord[6], 0);
            chk("st_pc_hold", imem_addr, 2);
        end
        step(); dmem_ack = 1'b0;
        #1 chk("st_done_addr", imem_addr, 3);

        jmp_to(7, 10, "jmp_fwd");

        // PC10: BRZ -2, taken then not taken
        do_fetch(enc(5, 0, 2, 0, 0, 4'b1110), 0);
        a_bus = 4'd0; step(); #1 chk("brz_taken", imem_addr, 8);
        jmp_to(2, 10, "jmp_back_10");
        do_fetch(enc(5, 0, 2, 0, 0, 4'b1110), 0);
        a_bus = 4'd3; step(); #1 chk("brz_not_taken", imem_addr, 11);
        a_bus = 4'd0;

        jmp_to(4'b1000, 3, "jmp_minus8");
        jmp_to(4'b1101, 0, "jmp_minus3");
        jmp_to(4'b1111, 255, "jmp_wrap_down");
        jmp_to(1, 0, "jmp_wrap_up");

        // PC0: NOP with a two-cycle fetch stall; PC1: opcode 12 acts as NOP
        do_fetch(enc(0, 1, 1, 1, 1, 1), 2);
        step(); #1 chk("nop_addr", imem_addr, 1);
        do_fetch(enc(12, 3, 3, 3, 15, 15), 0);
        #1 chk("op12_rw", ControlWord[0], 0);
        step(); #1 chk("op12_addr", imem_addr, 2);

        // PC2: ALU R3 = R1 op R2
        do_fetch(enc(1, 3, 1, 2, 4'b0101, 4'b1010), 0);
        #1 chk("alu_cw", ControlWord, 13'b11_01_10_0_0101_0_1);
        step(); #1 chk("alu_addr", imem_addr, 3);

        // PC3: HALT; acks while halted are ignored; start restarts at 0
        do_fetch(enc(7, 0, 0, 0, 0, 0), 0);
        step();
        #1 chk("halt_halted", halted, 1);
        chk("halt_busy", busy, 0);
        chk("halt_cw", ControlWord, 0);
        chk("halt_pc", imem_addr, 3);
        imem_data = enc(1, 1, 1, 1, 1, 1); imem_ack = 1'b1; dmem_ack = 1'b1;
        step(); step();
        imem_ack = 1'b0; dmem_ack = 1'b0;
        #1 chk("halt_ack_ignored", halted, 1);
        chk("halt_no_req", imem_req, 0);
        start = 1'b1; step(); start = 1'b0;
        #1 chk("restart_addr", imem_addr, 0);
        chk("restart_busy", busy, 1);

        // PC0: LD, then reset mid-MEM
        do_fetch(enc(3, 1, 2, 0, 0, 0), 0);
        step();
        #1 chk("pre_rst_dreq", dmem_req, 1);
        RSTn = 1'b0;
        #1 chk("async_dreq", dmem_req, 0);
        chk("async_cw", ControlWord, 0);
        chk("async_busy", busy, 0);
        step(); RSTn = 1'b1;
        dmem_ack = 1'b1; imem_ack = 1'b1;
        step(); step();
        dmem_ack = 1'b0; imem_ack = 1'b0;
        #1 chk("post_rst_idle", busy, 0);
        chk("post_rst_pc", imem_addr, 0);
        chk("post_rst_dreq", dmem_req, 0);
        step();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
